// File: rtl/live_value_table_2w4r_pkg.sv
// Shared widths, types and bank-index constants for the 2W/4R live value table
// and its companion data banks.
package live_value_table_2w4r_pkg;

  localparam int ADDR_WIDTH  = 5;
  localparam int ENTRY_WIDTH = 1;
  localparam int DEPTH       = 2 ** ADDR_WIDTH;

  typedef logic [ADDR_WIDTH-1:0]  addr_t;
  typedef logic [ENTRY_WIDTH-1:0] lvt_entry_t;

  localparam lvt_entry_t BANK0 = lvt_entry_t'(0);
  localparam lvt_entry_t BANK1 = lvt_entry_t'(1);

endpackage

// File: rtl/live_value_table_2w4r.sv
// Live value table: records which write port last wrote each address so the
// four read ports can steer their 2:1 word muxes to the live data bank.
module live_value_table_2w4r
  import live_value_table_2w4r_pkg::*;
#(
  parameter int ADDR_WIDTH  = live_value_table_2w4r_pkg::ADDR_WIDTH,
  parameter int ENTRY_WIDTH = live_value_table_2w4r_pkg::ENTRY_WIDTH
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   we0,
  input  logic [ADDR_WIDTH-1:0]  write_addr_0,
  input  logic                   we1,
  input  logic [ADDR_WIDTH-1:0]  write_addr_1,
  input  logic [ADDR_WIDTH-1:0]  read_addr_0,
  input  logic [ADDR_WIDTH-1:0]  read_addr_1,
  input  logic [ADDR_WIDTH-1:0]  read_addr_2,
  input  logic [ADDR_WIDTH-1:0]  read_addr_3,
  output logic [ENTRY_WIDTH-1:0] read_0,
  output logic [ENTRY_WIDTH-1:0] read_1,
  output logic [ENTRY_WIDTH-1:0] read_2,
  output logic [ENTRY_WIDTH-1:0] read_3
);

  localparam int TABLE_DEPTH = 2 ** ADDR_WIDTH;

  logic [ENTRY_WIDTH-1:0] entry [TABLE_DEPTH];

  // Port 1 is assigned last so it wins a same-address collision.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < TABLE_DEPTH; i++) begin
        entry[i] <= ENTRY_WIDTH'(BANK0);
      end
    end else begin
      if (we0) entry[write_addr_0] <= ENTRY_WIDTH'(BANK0);
      if (we1) entry[write_addr_1] <= ENTRY_WIDTH'(BANK1);
    end
  end

  // No write bypass: reads see the pre-edge value until the clock edge.
  assign read_0 = entry[read_addr_0];
  assign read_1 = entry[read_addr_1];
  assign read_2 = entry[read_addr_2];
  assign read_3 = entry[read_addr_3];

endmodule

// File: tb/tb_live_value_table_2w4r.sv
// Directed bench for the 2W/4R live value table with a "last writer" model
// checked on every falling clock edge plus literal spot checks.
module tb_live_value_table_2w4r;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       we0, we1;
  logic [4:0] write_addr_0, write_addr_1;
  logic [4:0] ra [4];
  logic [0:0] rd [4];

  int  total_cnt = 0;
  int  pass_cnt  = 0;
  bit  run = 1'b0;
  logic model [32];

  live_value_table_2w4r dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .we0          (we0),
    .write_addr_0 (write_addr_0),
    .we1          (we1),
    .write_addr_1 (write_addr_1),
    .read_addr_0  (ra[0]),
    .read_addr_1  (ra[1]),
    .read_addr_2  (ra[2]),
    .read_addr_3  (ra[3]),
    .read_0       (rd[0]),
    .read_1       (rd[1]),
    .read_2       (rd[2]),
    .read_3       (rd[3])
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic actual, input logic expected);
    total_cnt++;
    if (actual !== expected)
      $display("FAIL %s: got %b, required %b (t=%0t)", name, actual, expected, $time);
    else
      pass_cnt++;
  endtask

  // Model: entry holds the index of the last port that wrote it, port 1 winning ties.
  always @(negedge clock) begin
    if (run) begin
      for (int k = 0; k < 4; k++) begin
        total_cnt++;
        if (rd[k] !== model[ra[k]])
          $display("FAIL model_port%0d addr %0d: got %b, required %b (t=%0t)",
                   k, ra[k], rd[k], model[ra[k]], $time);
        else
          pass_cnt++;
      end
    end
  end

  task automatic set_reads(input int a0, input int a1, input int a2, input int a3);
    ra[0] = 5'(a0); ra[1] = 5'(a1); ra[2] = 5'(a2); ra[3] = 5'(a3);
  endtask

  task automatic clear_model();
    for (int i = 0; i < 32; i++) model[i] = 1'b0;
  endtask

  // Inputs are applied 1 time unit after a rising edge and released after the next one.
  task automatic step(input logic w0, input int a0, input logic w1, input int a1);
    we0 = w0; write_addr_0 = 5'(a0);
    we1 = w1; write_addr_1 = 5'(a1);
    @(posedge clock);
    if (reset_n) begin
      if (w0) model[a0] = 1'b0;
      if (w1) model[a1] = 1'b1;
    end
    #1;
    we0 = 1'b0; we1 = 1'b0;
  endtask

  initial begin
    reset_n = 1'b0;
    we0 = 1'b0; we1 = 1'b0; write_addr_0 = '0; write_addr_1 = '0;
    set_reads(0, 7, 19, 31);
    clear_model();
    #12;
    reset_n = 1'b1;
    @(posedge clock); #1;
    run = 1'b1;
    check("reset_state_a0", rd[0], 1'b0);
    check("reset_state_a31", rd[3], 1'b0);

    // Populate entries, then reset mid-cycle and expect zeros before the next edge.
    step(1'b0, 0, 1'b1, 0);
    step(1'b0, 0, 1'b1, 7);
    step(1'b0, 0, 1'b1, 19);
    step(1'b0, 0, 1'b1, 31);
    check("prefill_a19", rd[2], 1'b1);
    #2;
    reset_n = 1'b0;
    clear_model();
    #1;
    check("async_rst_a0", rd[0], 1'b0);
    check("async_rst_a7", rd[1], 1'b0);
    check("async_rst_a19", rd[2], 1'b0);
    check("async_rst_a31", rd[3], 1'b0);
    @(posedge clock); #3;
    reset_n = 1'b1;
    @(posedge clock); #1;

    // Single writes.
    set_reads(3, 5, 4, 0);
    step(1'b1, 3, 1'b0, 0);
    step(1'b0, 0, 1'b1, 5);
    check("single_w0_a3", rd[0], 1'b0);
    check("single_w1_a5", rd[1], 1'b1);
    check("untouched_a4", rd[2], 1'b0);

    // Same-address collision: port 1 wins; later port-0 write reclaims it.
    set_reads(9, 9, 9, 9);
    step(1'b1, 9, 1'b1, 9);
    check("collide_a9", rd[0], 1'b1);
    step(1'b1, 9, 1'b0, 0);
    check("reclaim_a9", rd[3], 1'b0);

    // Dual write to different addresses.
    set_reads(2, 18, 2, 18);
    step(1'b1, 2, 1'b1, 18);
    check("dual_a2", rd[0], 1'b0);
    check("dual_a18", rd[1], 1'b1);
    set_reads(18, 18, 18, 18);
    #1;
    for (int k = 0; k < 4; k++) check($sformatf("all_ports_a18_p%0d", k), rd[k], 1'b1);

    // Read during write: old value before the edge, new value right after.
    set_reads(0, 1, 12, 13);
    we1 = 1'b1; write_addr_1 = 5'd12;
    #2;
    check("rdw_before_edge", rd[2], 1'b0);
    @(posedge clock);
    model[12] = 1'b1;
    #1;
    we1 = 1'b0;
    check("rdw_after_edge", rd[2], 1'b1);

    // Fill the table via port 1, then reset while a port-1 write is held.
    for (int i = 0; i < 32; i++) step(1'b0, 0, 1'b1, i);
    set_reads(6, 14, 22, 30);
    #1;
    check("filled_a22", rd[2], 1'b1);
    we1 = 1'b1; write_addr_1 = 5'd6;
    #2;
    reset_n = 1'b0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    for (int i = 0; i < 32; i += 4) begin
      set_reads(i, i + 1, i + 2, i + 3);
      #1;
      for (int k = 0; k < 4; k++)
        check($sformatf("held_rst_a%0d", i + k), rd[k], 1'b0);
    end
    @(posedge clock); #1;
    we1 = 1'b0;
    #2;
    reset_n = 1'b1;
    set_reads(20, 6, 21, 19);
    @(posedge clock); #1;
    step(1'b0, 0, 1'b1, 20);
    check("post_rst_write_a20", rd[0], 1'b1);
    check("post_rst_a6", rd[1], 1'b0);
    check("post_rst_a21", rd[2], 1'b0);

    repeat (2) @(posedge clock);
    #1;
    run = 1'b0;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
